// File: rtl/layers_readout_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : layers_readout_word_packer_if
// Brief    : Byte-in / word-out AXI-Stream bundle for the readout word packer.
// Revision : 1.0
// ============================================================================
interface layers_readout_word_packer_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  // Packer side: consumes bytes, produces words.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  // Environment side: produces bytes, consumes words.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/layers_readout_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : layers_readout_word_packer
// Brief    : Packs the readout byte stream into 32-bit LE words with tkeep/tlast.
// Revision : 1.0
// ============================================================================
module layers_readout_word_packer #(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         TIMEOUT_W = 16
) (
  input  logic                          clk_core,
  input  logic                          clk_core_rst,
  layers_readout_word_packer_if.slave   bus,
  input  logic                          cfg_enable,
  input  logic [TIMEOUT_W-1:0]          cfg_flush_timeout,
  output logic [31:0]                   stat_words,
  output logic [31:0]                   stat_frames,
  output logic [15:0]                   stat_timeout_flush
);

  localparam logic [2:0] FILL_EMPTY = 3'd0;
  localparam logic [2:0] FILL_LANE3 = 3'd3;

  // Assembly stage; r_fill counts filled lanes (0..4), so it doubles as next lane index.
  logic [31:0]          r_asm_data;
  logic [2:0]           r_fill;
  logic                 r_pending;
  logic                 r_asm_last;

  logic [31:0]          r_out_data;
  logic [3:0]           r_out_keep;
  logic                 r_out_valid;
  logic                 r_out_last;

  logic [TIMEOUT_W-1:0] r_idle;
  logic [31:0]          r_stat_words;
  logic [31:0]          r_stat_frames;
  logic [15:0]          r_stat_timeout;

  logic                 w_slot_free;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_move;
  logic [2:0]           w_base_fill;
  logic [TIMEOUT_W-1:0] w_idle_next;
  logic                 w_flush;
  logic [3:0]           w_keep;
  logic                 w_word_xfer;

  assign w_slot_free = !r_out_valid | bus.m_axis_tready;
  assign w_ready     = cfg_enable & (!r_pending | w_slot_free);
  assign w_accept    = bus.s_axis_tvalid & w_ready;
  assign w_move      = r_pending & w_slot_free;
  assign w_base_fill = w_move ? FILL_EMPTY : r_fill;
  assign w_idle_next = (&r_idle) ? r_idle : r_idle + 1'b1;
  assign w_word_xfer = r_out_valid & bus.m_axis_tready;

  // Flush fires on the cycle the idle count would reach the threshold; an accept always wins.
  assign w_flush = !r_pending & (r_fill != FILL_EMPTY) & (cfg_flush_timeout != '0)
                 & (w_idle_next >= cfg_flush_timeout) & !w_accept;

  always_comb begin
    w_keep = 4'hF;
    case (r_fill)
      3'd1:    w_keep = 4'h1;
      3'd2:    w_keep = 4'h3;
      3'd3:    w_keep = 4'h7;
      default: w_keep = 4'hF;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      r_asm_data     <= '0;
      r_fill         <= FILL_EMPTY;
      r_pending      <= 1'b0;
      r_asm_last     <= 1'b0;
      r_out_data     <= '0;
      r_out_keep     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_idle         <= '0;
      r_stat_words   <= '0;
      r_stat_frames  <= '0;
      r_stat_timeout <= '0;
    end else begin
      if (w_move) begin
        r_pending <= 1'b0;
        r_fill    <= FILL_EMPTY;
      end

      if (w_accept) begin
        // Starting a new word pre-fills the upper lanes with padding.
        if (w_base_fill == FILL_EMPTY)
          r_asm_data <= {{3{PAD_BYTE}}, bus.s_axis_tdata};
        else
          r_asm_data[{w_base_fill[1:0], 3'b000} +: 8] <= bus.s_axis_tdata;
        r_fill     <= w_base_fill + 3'd1;
        r_asm_last <= bus.s_axis_tlast;
        if (w_base_fill == FILL_LANE3 || bus.s_axis_tlast)
          r_pending <= 1'b1;
      end else if (w_flush) begin
        r_pending  <= 1'b1;
        r_asm_last <= 1'b0;
        if (r_stat_timeout != 16'hFFFF)
          r_stat_timeout <= r_stat_timeout + 16'd1;
      end

      if (w_slot_free) begin
        r_out_valid <= r_pending;
        if (r_pending) begin
          r_out_data <= r_asm_data;
          r_out_keep <= w_keep;
          r_out_last <= r_asm_last;
        end
      end

      if (w_accept || w_flush || (r_fill == FILL_EMPTY && !r_pending))
        r_idle <= '0;
      else
        r_idle <= w_idle_next;

      if (w_word_xfer) begin
        r_stat_words <= r_stat_words + 32'd1;
        if (r_out_last)
          r_stat_frames <= r_stat_frames + 32'd1;
      end
    end
  end

  assign bus.s_axis_tready = w_ready;
  assign bus.m_axis_tdata  = r_out_data;
  assign bus.m_axis_tkeep  = r_out_keep;
  assign bus.m_axis_tvalid = r_out_valid;
  assign bus.m_axis_tlast  = r_out_last;

  assign stat_words         = r_stat_words;
  assign stat_frames        = r_stat_frames;
  assign stat_timeout_flush = r_stat_timeout;

endmodule
`default_nettype wire

// File: tb/tb_layers_readout_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layers_readout_word_packer
// Brief    : Self-checking bench for the readout word packer against a byte->word model.
// Revision : 1.0
// ============================================================================
module tb_layers_readout_word_packer;

  logic        clk_core = 1'b0;
  logic        clk_core_rst;
  logic        cfg_enable;
  logic [15:0] cfg_flush_timeout;
  logic [31:0] stat_words;
  logic [31:0] stat_frames;
  logic [15:0] stat_timeout_flush;

  always #5 clk_core = ~clk_core;

  layers_readout_word_packer_if bus ();

  layers_readout_word_packer #(
    .PAD_BYTE  (8'h00),
    .TIMEOUT_W (16)
  ) dut (
    .clk_core           (clk_core),
    .clk_core_rst       (clk_core_rst),
    .bus                (bus),
    .cfg_enable         (cfg_enable),
    .cfg_flush_timeout  (cfg_flush_timeout),
    .stat_words         (stat_words),
    .stat_frames        (stat_frames),
    .stat_timeout_flush (stat_timeout_flush)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt;
  bit          rand_rdy = 1'b0;
  bit          drain_ok;
  logic [36:0] got[$];    // {last, keep, data}
  logic [36:0] exp_q[$];
  logic [8:0]  in_q[$];   // {last, byte}

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk_core)
    if (!clk_core_rst && bus.m_axis_tvalid && bus.m_axis_tready)
      got.push_back({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata});

  // Reference: bytes fill lanes 0..3 in order; a word closes when full or on frame end.
  function automatic void model_pack();
    logic [31:0] d = '0;
    int          n = 0;
    foreach (in_q[i]) begin
      d[8*n +: 8] = in_q[i][7:0];
      n++;
      if (n == 4 || in_q[i][8]) begin
        exp_q.push_back({in_q[i][8], 4'((1 << n) - 1), d});
        d = '0;
        n = 0;
      end
    end
    in_q.delete();
  endfunction

  function automatic int count_last();
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i][36]) c++;
    return c;
  endfunction

  task automatic do_reset();
    clk_core_rst = 1'b1;
    @(posedge clk_core); #1;
    clk_core_rst = 1'b0;
    got.delete(); exp_q.delete(); in_q.delete();
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    bit acc = 1'b0;
    int waited = 0;
    bus.s_axis_tdata = d; bus.s_axis_tlast = l; bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk_core);
      if (bus.s_axis_tready) acc = 1'b1; else waited++;
      @(posedge clk_core); #1;
      if (rand_rdy) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    if (waited != 0) stall_cnt++;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_accept byte=%h never accepted within 300 cycles", d);
    end else in_q.push_back({l, d});
  endtask

  task automatic wait_drain();
    drain_ok = 1'b0;
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (got.size() >= exp_q.size() && !bus.m_axis_tvalid) begin drain_ok = 1'b1; break; end
      @(posedge clk_core); #1;
    end
    repeat (4) @(posedge clk_core);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got=%b required=0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.m_axis_tdata !== 32'h0) begin n_bad++; $display("FAIL rst_tdata got=%h required=0", bus.m_axis_tdata); end
    n_cmp++; if (bus.m_axis_tkeep !== 4'h0) begin n_bad++; $display("FAIL rst_tkeep got=%h required=0", bus.m_axis_tkeep); end
    n_cmp++; if (bus.m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got=%b required=0", bus.m_axis_tlast); end
    n_cmp++; if (stat_words !== 32'd0) begin n_bad++; $display("FAIL rst_stat_words got=%0d required=0", stat_words); end
    n_cmp++; if (stat_frames !== 32'd0) begin n_bad++; $display("FAIL rst_stat_frames got=%0d required=0", stat_frames); end
    n_cmp++; if (stat_timeout_flush !== 16'd0) begin n_bad++; $display("FAIL rst_stat_tmo got=%0d required=0", stat_timeout_flush); end
  endtask

  task automatic test_full_rate();
    do_reset();
    stall_cnt = 0;
    for (int i = 1; i <= 8; i++) push(8'(i), i == 8);
    model_pack();
    wait_drain();
    n_cmp++; if (stall_cnt !== 0) begin n_bad++; $display("FAIL full_rate_stalls got=%0d required=0", stall_cnt); end
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL full_rate_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_rate_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
    n_cmp++; if (stat_words !== 32'd2) begin n_bad++; $display("FAIL full_rate_stat_words got=%0d required=2", stat_words); end
    n_cmp++; if (stat_frames !== 32'd1) begin n_bad++; $display("FAIL full_rate_stat_frames got=%0d required=1", stat_frames); end
  endtask

  task automatic test_partial();
    logic [7:0] b[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_reset();
    foreach (b[i]) push(b[i], i == 4);
    model_pack();
    wait_drain();
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL partial_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL partial_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] f[20];
    int idx = 0;
    bit acc;
    do_reset();
    foreach (f[i]) f[i] = 8'(8'h30 + i);
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tdata = f[0]; bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_core); acc = bus.s_axis_tready;
      @(posedge clk_core); #1;
      if (acc) begin
        in_q.push_back({1'b0, f[idx]});
        idx++;
        bus.s_axis_tdata = f[idx];
      end
    end
    bus.s_axis_tvalid = 1'b0;
    n_cmp++; if (idx !== 8) begin n_bad++; $display("FAIL bp_buffered got=%0d bytes required=8", idx); end
    n_cmp++; if (bus.s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp_tready got=%b required=0", bus.s_axis_tready); end
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL bp_no_xfer got=%0d words required=0", got.size()); end
    bus.m_axis_tready = 1'b1;
    for (int i = idx; i < 20; i++) push(f[i], i == 19);
    model_pack();
    wait_drain();
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    cfg_flush_timeout = 16'd16;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_core); #1;
      if (bus.m_axis_tvalid) begin n = k; break; end
    end
    @(posedge clk_core); #1;
    n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL tmo_latency got=%0d cycles required=17", n); end
    n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL tmo_count got=%0d required=1", got.size()); end
    else begin
      n_cmp++; if (got[0] !== {1'b0, 4'h3, 32'h00002211}) begin n_bad++; $display("FAIL tmo_word got=%h required=%h", got[0], {1'b0, 4'h3, 32'h00002211}); end
    end
    n_cmp++; if (stat_timeout_flush !== 16'd1) begin n_bad++; $display("FAIL tmo_stat got=%0d required=1", stat_timeout_flush); end
    n_cmp++; if (stat_frames !== 32'd0) begin n_bad++; $display("FAIL tmo_frames got=%0d required=0", stat_frames); end
    cfg_flush_timeout = 16'd0;
    in_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_core); #1;
      if (bus.m_axis_tvalid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_tvalid got=%0d valid cycles required=0", seen); end
    n_cmp++; if (stat_words !== 32'd0) begin n_bad++; $display("FAIL rstmid_words got=%0d required=0", stat_words); end
    n_cmp++; if (stat_frames !== 32'd0) begin n_bad++; $display("FAIL rstmid_frames got=%0d required=0", stat_frames); end
    for (int i = 0; i < 4; i++) push(8'(8'h0A + i), i == 3);
    model_pack();
    wait_drain();
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL rstmid_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable();
    int rdy_seen = 0;
    do_reset();
    push(8'h51, 1'b0); push(8'h52, 1'b0);
    cfg_enable = 1'b0;
    bus.s_axis_tdata = 8'h53; bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_core); if (bus.s_axis_tready) rdy_seen++;
      @(posedge clk_core); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL en_tready got=%0d ready cycles required=0", rdy_seen); end
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL en_held got=%0d words required=0", got.size()); end
    cfg_enable = 1'b1;
    for (int i = 3; i <= 9; i++) push(8'(8'h50 + i), i == 9);
    model_pack();
    wait_drain();
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL en_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL en_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    rand_rdy = 1'b1;
    for (int fr = 0; fr < 10; fr++) begin
      len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) begin
        push(8'($urandom), i == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk_core); #1;
          bus.m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    end
    rand_rdy = 1'b0;
    model_pack();
    wait_drain();
    n_cmp++; if (!drain_ok || got.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count got=%0d required=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word%0d got=%h required=%h", i, got[i], exp_q[i]); end
    end
    n_cmp++; if (stat_words !== 32'(exp_q.size())) begin n_bad++; $display("FAIL rand_stat_words got=%0d required=%0d", stat_words, exp_q.size()); end
    n_cmp++; if (stat_frames !== 32'(count_last())) begin n_bad++; $display("FAIL rand_stat_frames got=%0d required=%0d", stat_frames, count_last()); end
  endtask

  initial begin
    clk_core_rst = 1'b1;
    cfg_enable = 1'b1;
    cfg_flush_timeout = 16'd0;
    bus.s_axis_tdata = 8'h00; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk_core);
    #1;
    clk_core_rst = 1'b0;
    test_reset();
    test_full_rate();
    test_partial();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
